// File: rtl/bottle_fill_sequencer.sv
// bottle_fill_sequencer
//   Pill bottling fill controller. Counts hopper pill strobes into the current
//   bottle in BCD, requests a conveyor advance when a bottle is full, and
//   watches hopper and conveyor timeouts.
//   Optional feature macro: FILL_ERR_COUNT_EN adds an 8-bit saturating count of
//   ERROR entries (err_count), cleared only by switch_clr.
//   Handshake note: start, ack and pill_pulse are single-cycle strobes sampled
//   on the rising clock edge; bottle_switch is a single-cycle registered strobe
//   with no back-pressure. emergency_stop and conveyor_ok are levels.
//   The FSM state is exposed directly on the state output.
module bottle_fill_sequencer #(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int SWITCH_SEC     = 2,
  parameter int HOPPER_TMO_SEC = 3
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        start,
  input  logic        ack,
  input  logic        emergency_stop,
  input  logic        pill_pulse,
  input  logic        conveyor_ok,
  input  logic [11:0] tgt_pills,
  input  logic [7:0]  tgt_bottles,
  output logic [11:0] now_pills,
  output logic [7:0]  now_bottles,
  output logic [2:0]  state,
  output logic        err_cause,
`ifdef FILL_ERR_COUNT_EN
  output logic [7:0]  err_count,
`endif
  output logic        bottle_switch
);

  localparam int HOPPER_TICKS = HOPPER_TMO_SEC * TICKS_PER_SEC;
  localparam int SWITCH_TICKS = SWITCH_SEC * TICKS_PER_SEC;
  localparam int HW = $clog2(HOPPER_TICKS + 1);
  localparam int SW = $clog2(SWITCH_TICKS + 1);
  localparam logic [HW-1:0] HOPPER_LOAD = HW'(HOPPER_TICKS);
  localparam logic [SW-1:0] SWITCH_LOAD = SW'(SWITCH_TICKS);

  typedef enum logic [2:0] {
    S_SETTING   = 3'd0,
    S_RUNNING   = 3'd1,
    S_SWITCHING = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4,
    S_FATAL     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   pills_d;
  logic [7:0]    bottles_d;
  logic          cause_d;
  logic          switch_d;
  logic [HW-1:0] hop_q, hop_d;
  logic [SW-1:0] sw_q, sw_d;
  logic          err_entry;
  logic          take_pill;
  logic [11:0]   pill_inc;
  logic [7:0]    bottle_inc;
  logic          bottle_full;
  logic          run_last;

  // Three-digit BCD increment, each digit 9 rolls to 0 and carries upward
  function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
    logic [11:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two-digit BCD increment
  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    logic [7:0] r;
    logic       carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign pill_inc    = bcd_inc3(now_pills);
  assign bottle_inc  = bcd_inc2(now_bottles);
  assign bottle_full = (pill_inc == tgt_pills);
  assign run_last    = (bottle_inc == tgt_bottles);
  assign state       = state_q;

  // State register
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_q <= S_SETTING;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter and timer updates; emergency_stop overrides everything
  always_comb begin
    state_d   = state_q;
    pills_d   = now_pills;
    bottles_d = now_bottles;
    cause_d   = err_cause;
    switch_d  = 1'b0;
    hop_d     = hop_q;
    sw_d      = sw_q;
    err_entry = 1'b0;
    take_pill = 1'b0;

    if (emergency_stop) begin
      state_d = S_FATAL;
    end else begin
      case (state_q)
        S_SETTING: begin
          if (start && (tgt_pills != 12'h000) && (tgt_bottles != 8'h00)) begin
            state_d   = S_RUNNING;
            pills_d   = 12'h000;
            bottles_d = 8'h00;
            hop_d     = HOPPER_LOAD;
          end
        end
        S_RUNNING: begin
          // A pill on the expiry cycle beats the timeout
          if (pill_pulse) begin
            take_pill = 1'b1;
          end else if (hop_q <= HW'(1)) begin
            hop_d     = '0;
            state_d   = S_ERROR;
            cause_d   = 1'b0;
            err_entry = 1'b1;
          end else begin
            hop_d = hop_q - HW'(1);
          end
        end
        S_SWITCHING: begin
          // The timer reaching zero ends the settle window
          if (sw_q <= SW'(1)) begin
            sw_d = '0;
            if (conveyor_ok) begin
              state_d = S_RUNNING;
              pills_d = 12'h000;
              hop_d   = HOPPER_LOAD;
            end else begin
              state_d   = S_ERROR;
              cause_d   = 1'b1;
              err_entry = 1'b1;
            end
          end else begin
            sw_d = sw_q - SW'(1);
          end
        end
        S_ERROR: begin
          if (!err_cause) begin
            if (pill_pulse) begin
              take_pill = 1'b1;
            end
          end else if (conveyor_ok) begin
            state_d = S_RUNNING;
            pills_d = 12'h000;
            hop_d   = HOPPER_LOAD;
          end
        end
        S_DONE: begin
          if (ack) begin
            state_d = S_SETTING;
          end
        end
        S_FATAL: begin
          if (ack) begin
            state_d   = S_SETTING;
            pills_d   = 12'h000;
            bottles_d = 8'h00;
          end
        end
        default: begin
          state_d = S_SETTING;
        end
      endcase

      // Counting a pill, shared by RUNNING and hopper-timeout recovery
      if (take_pill) begin
        state_d = S_RUNNING;
        pills_d = pill_inc;
        hop_d   = HOPPER_LOAD;
        if (bottle_full) begin
          bottles_d = bottle_inc;
          if (run_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_SWITCHING;
            switch_d = 1'b1;
            sw_d     = SWITCH_LOAD;
          end
        end
      end
    end
  end

  // Registered counters, timers and outputs
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      now_pills     <= 12'h000;
      now_bottles   <= 8'h00;
      err_cause     <= 1'b0;
      bottle_switch <= 1'b0;
      hop_q         <= '0;
      sw_q          <= '0;
    end else begin
      now_pills     <= pills_d;
      now_bottles   <= bottles_d;
      err_cause     <= cause_d;
      bottle_switch <= switch_d;
      hop_q         <= hop_d;
      sw_q          <= sw_d;
    end
  end

`ifdef FILL_ERR_COUNT_EN
  // Saturating count of ERROR entries
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      err_count <= 8'd0;
    end else if (err_entry && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_err_entry;
  assign unused_err_entry = err_entry;
`endif

endmodule

// File: tb/tb_bottle_fill_sequencer.sv
// Directed testbench for bottle_fill_sequencer.
// Build with FILL_ERR_COUNT_EN defined to also cover err_count.
`timescale 1ns/1ps
module tb_bottle_fill_sequencer;

  logic        clk_1khz = 1'b0;
  logic        switch_clr;
  logic        start;
  logic        ack;
  logic        emergency_stop;
  logic        pill_pulse;
  logic        conveyor_ok;
  logic [11:0] tgt_pills;
  logic [7:0]  tgt_bottles;
  logic [11:0] now_pills;
  logic [7:0]  now_bottles;
  logic [2:0]  state;
  logic        err_cause;
  logic        bottle_switch;
`ifdef FILL_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  bottle_fill_sequencer dut (
    .clk_1khz       (clk_1khz),
    .switch_clr     (switch_clr),
    .start          (start),
    .ack            (ack),
    .emergency_stop (emergency_stop),
    .pill_pulse     (pill_pulse),
    .conveyor_ok    (conveyor_ok),
    .tgt_pills      (tgt_pills),
    .tgt_bottles    (tgt_bottles),
    .now_pills      (now_pills),
    .now_bottles    (now_bottles),
    .state          (state),
    .err_cause      (err_cause),
`ifdef FILL_ERR_COUNT_EN
    .err_count      (err_count),
`endif
    .bottle_switch  (bottle_switch)
  );

  // Clock
  always #5 clk_1khz = ~clk_1khz;

  // Scoreboard: every bottle_switch must match an expected now_bottles value
  always @(negedge clk_1khz) begin
    if (switch_clr && bottle_switch) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL switch_unexpected: bottle_switch=1 now_bottles=%h, none expected", now_bottles);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (now_bottles !== e) begin
          errors++;
          $display("FAIL switch_bottles: now_bottles=%h expected=%h", now_bottles, e);
        end
      end
    end
  end

  // Driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic step();
    @(posedge clk_1khz);
    @(negedge clk_1khz);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pill();
    pill_pulse = 1'b1;
    step();
    pill_pulse = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_1khz);
    switch_clr = 1'b0;
    step();
    switch_clr = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 switch_clr = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: state=%0d expected=0", state); end
    checks++; if (now_pills !== 12'h000) begin errors++; $display("FAIL reset_pills: now_pills=%h expected=000", now_pills); end
    checks++; if (now_bottles !== 8'h00) begin errors++; $display("FAIL reset_bottles: now_bottles=%h expected=00", now_bottles); end
    checks++; if (err_cause !== 1'b0) begin errors++; $display("FAIL reset_cause: err_cause=%b expected=0", err_cause); end
    checks++; if (bottle_switch !== 1'b0) begin errors++; $display("FAIL reset_switch: bottle_switch=%b expected=0", bottle_switch); end
`ifdef FILL_ERR_COUNT_EN
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: err_count=%0d expected=0", err_count); end
`endif
    @(negedge clk_1khz);
    switch_clr = 1'b1;
    step();
  endtask

  task automatic test_fill_run();
    int sw_cycles;
    tgt_pills   = 12'h003;
    tgt_bottles = 8'h02;
    pulse_start();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_start: state=%0d expected=1", state); end
    checks++; if (now_pills !== 12'h000) begin errors++; $display("FAIL run_start_pills: now_pills=%h expected=000", now_pills); end
    for (int p = 1; p <= 6; p++) begin
      idle(99);
      if (p == 3) exp_q.push_back(8'h01);
      pill();
      if (p == 3) begin
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL run_switching: state=%0d expected=2", state); end
        checks++; if (now_pills !== 12'h003) begin errors++; $display("FAIL run_full_pills: now_pills=%h expected=003", now_pills); end
        sw_cycles = 1;
        for (int i = 0; i < 2100; i++) begin
          step();
          if (state == 3'd2) sw_cycles++;
          else break;
        end
        checks++; if (sw_cycles != 2000) begin errors++; $display("FAIL run_switch_len: cycles=%0d expected=2000", sw_cycles); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_resume: state=%0d expected=1", state); end
        checks++; if (now_pills !== 12'h000) begin errors++; $display("FAIL run_resume_pills: now_pills=%h expected=000", now_pills); end
      end
    end
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL run_done: state=%0d expected=3", state); end
    checks++; if (now_bottles !== 8'h02) begin errors++; $display("FAIL run_done_bottles: now_bottles=%h expected=02", now_bottles); end
    checks++; if (now_pills !== 12'h003) begin errors++; $display("FAIL run_done_pills: now_pills=%h expected=003", now_pills); end
    pulse_start();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL done_start_ignored: state=%0d expected=3", state); end
    pulse_ack();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL done_ack: state=%0d expected=0", state); end
    checks++; if (now_bottles !== 8'h02) begin errors++; $display("FAIL done_ack_hold: now_bottles=%h expected=02", now_bottles); end
  endtask

  task automatic test_zero_target();
    tgt_pills   = 12'h000;
    tgt_bottles = 8'h02;
    pulse_start();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL zero_pills: state=%0d expected=0", state); end
    tgt_pills   = 12'h005;
    tgt_bottles = 8'h00;
    pulse_start();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL zero_bottles: state=%0d expected=0", state); end
    pill();
    checks++; if (now_pills !== 12'h003) begin errors++; $display("FAIL setting_pill_ignored: now_pills=%h expected=003", now_pills); end
  endtask

  task automatic test_hopper_timeout();
    tgt_pills   = 12'h005;
    tgt_bottles = 8'h03;
    pulse_start();
    pill();
    idle(2999);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL hopper_before: state=%0d expected=1", state); end
    step();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL hopper_error: state=%0d expected=4", state); end
    checks++; if (err_cause !== 1'b0) begin errors++; $display("FAIL hopper_cause: err_cause=%b expected=0", err_cause); end
    pill();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL hopper_recover: state=%0d expected=1", state); end
    checks++; if (now_pills !== 12'h002) begin errors++; $display("FAIL hopper_recover_pills: now_pills=%h expected=002", now_pills); end
    idle(2999);
    pill();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL hopper_pill_wins: state=%0d expected=1", state); end
    checks++; if (now_pills !== 12'h003) begin errors++; $display("FAIL hopper_pill_wins_pills: now_pills=%h expected=003", now_pills); end
    switch_clr = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL midrun_reset_state: state=%0d expected=0", state); end
    checks++; if (now_pills !== 12'h000) begin errors++; $display("FAIL midrun_reset_pills: now_pills=%h expected=000", now_pills); end
    step();
    switch_clr = 1'b1;
    step();
  endtask

  task automatic test_conveyor_fault();
    tgt_pills   = 12'h002;
    tgt_bottles = 8'h03;
    pulse_start();
    pill();
    exp_q.push_back(8'h01);
    pill();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL conv_switching: state=%0d expected=2", state); end
    conveyor_ok = 1'b0;
    idle(1999);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL conv_before: state=%0d expected=2", state); end
    step();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL conv_error: state=%0d expected=4", state); end
    checks++; if (err_cause !== 1'b1) begin errors++; $display("FAIL conv_cause: err_cause=%b expected=1", err_cause); end
    pill();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL conv_pill_ignored: state=%0d expected=4", state); end
    checks++; if (now_pills !== 12'h002) begin errors++; $display("FAIL conv_pill_ignored_pills: now_pills=%h expected=002", now_pills); end
    conveyor_ok = 1'b1;
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL conv_recover: state=%0d expected=1", state); end
    checks++; if (now_pills !== 12'h000) begin errors++; $display("FAIL conv_recover_pills: now_pills=%h expected=000", now_pills); end
    checks++; if (now_bottles !== 8'h01) begin errors++; $display("FAIL conv_recover_bottles: now_bottles=%h expected=01", now_bottles); end
  endtask

  task automatic test_emergency_stop();
    pill();
    exp_q.push_back(8'h02);
    pill();
    idle(10);
    emergency_stop = 1'b1;
    step();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL estop_fatal: state=%0d expected=5", state); end
    checks++; if (now_bottles !== 8'h02) begin errors++; $display("FAIL estop_freeze: now_bottles=%h expected=02", now_bottles); end
    pulse_ack();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL estop_ack_held: state=%0d expected=5", state); end
    emergency_stop = 1'b0;
    step();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL estop_release: state=%0d expected=5", state); end
    pulse_ack();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL estop_ack: state=%0d expected=0", state); end
    checks++; if (now_pills !== 12'h000) begin errors++; $display("FAIL estop_clear_pills: now_pills=%h expected=000", now_pills); end
    checks++; if (now_bottles !== 8'h00) begin errors++; $display("FAIL estop_clear_bottles: now_bottles=%h expected=00", now_bottles); end
  endtask

  task automatic test_bcd_carry();
    bit timed_out;
    do_reset();
    tgt_pills   = 12'h010;
    tgt_bottles = 8'h02;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      pill();
      idle(1);
    end
    checks++; if (now_pills !== 12'h009) begin errors++; $display("FAIL bcd_nine: now_pills=%h expected=009", now_pills); end
    exp_q.push_back(8'h01);
    pill();
    checks++; if (now_pills !== 12'h010) begin errors++; $display("FAIL bcd_carry: now_pills=%h expected=010", now_pills); end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL bcd_switch: state=%0d expected=2", state); end
    conveyor_ok = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      step();
      if (state != 3'd2) begin timed_out = 1'b0; break; end
    end
    checks++; if (timed_out) begin errors++; $display("FAIL bcd_switch_timeout: state=%0d still 2 after 2100 cycles", state); end
    checks++; if (state !== 3'd4 || err_cause !== 1'b1) begin errors++; $display("FAIL bcd_err1: state=%0d cause=%b expected=4/1", state, err_cause); end
    conveyor_ok = 1'b1;
    step();
    timed_out = 1'b1;
    for (int i = 0; i < 3100; i++) begin
      step();
      if (state != 3'd1) begin timed_out = 1'b0; break; end
    end
    checks++; if (timed_out) begin errors++; $display("FAIL bcd_hopper_timeout: state=%0d still 1 after 3100 cycles", state); end
    checks++; if (state !== 3'd4 || err_cause !== 1'b0) begin errors++; $display("FAIL bcd_err0: state=%0d cause=%b expected=4/0", state, err_cause); end
`ifdef FILL_ERR_COUNT_EN
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL err_count: err_count=%0d expected=2", err_count); end
`endif
  endtask

  initial begin
    switch_clr     = 1'b1;
    start          = 1'b0;
    ack            = 1'b0;
    emergency_stop = 1'b0;
    pill_pulse     = 1'b0;
    conveyor_ok    = 1'b1;
    tgt_pills      = 12'h000;
    tgt_bottles    = 8'h00;
    test_reset();
    test_fill_run();
    test_zero_target();
    test_hopper_timeout();
    test_conveyor_fault();
    test_emergency_stop();
    test_bcd_carry();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL switch_missing: %0d expected bottle_switch pulses not seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
